// File: rtl/ir_line_err_pkg.sv
// ir_line_err_pkg: shared types, saturation bounds and channel accumulation order
package ir_line_err_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   localparam int ERR_WIDTH = 16;
   localparam int ACC_WIDTH = 18;
   localparam int ERR_MAX = 2 ** (ERR_WIDTH - 1) - 1;
   localparam int ERR_MIN = -(2 ** (ERR_WIDTH - 1));
   // idx[2] selects the right bank, idx[1:0] is both sensor number and shift weight
   typedef struct packed {
      logic [2:0] idx;
      logic       sub;
   } ch_t;
   localparam ch_t [0:7] CH_ORDER = '{
      '{3'd4, 1'b0}, '{3'd0, 1'b1}, '{3'd5, 1'b0}, '{3'd1, 1'b1},
      '{3'd6, 1'b0}, '{3'd2, 1'b1}, '{3'd7, 1'b0}, '{3'd3, 1'b1}
   };
endpackage

// File: rtl/ir_line_err_if.sv
// ir_line_err_if: IR round inputs and line-error results
interface ir_line_err_if #(parameter int ERR_W = 16);
   logic                    IR_vld;
   logic                    line_present;
   logic [11:0]             IR_L0, IR_L1, IR_L2, IR_L3;
   logic [11:0]             IR_R0, IR_R1, IR_R2, IR_R3;
   logic signed [ERR_W-1:0] err;
   logic                    err_vld;
   logic                    line_lost;
   modport master (
      output IR_vld, line_present, IR_L0, IR_L1, IR_L2, IR_L3, IR_R0, IR_R1, IR_R2, IR_R3,
      input  err, err_vld, line_lost
   );
   modport slave (
      input  IR_vld, line_present, IR_L0, IR_L1, IR_L2, IR_L3, IR_R0, IR_R1, IR_R2, IR_R3,
      output err, err_vld, line_lost
   );
endinterface

// File: rtl/ir_err_sat.sv
// ir_err_sat: clamps a signed ACC_W value into the signed ERR_W range
module ir_err_sat #(
   parameter int ACC_W = 18,
   parameter int ERR_W = 16
) (
   input  logic signed [ACC_W-1:0] a,
   output logic signed [ERR_W-1:0] y
);
   localparam logic signed [ACC_W-1:0] HI = ACC_W'((1 <<< (ERR_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] LO = ~HI;
   always_comb y = (a > HI) ? ERR_W'(HI) : (a < LO) ? ERR_W'(LO) : ERR_W'(a);
endmodule

// File: rtl/ir_line_err.sv
// ir_line_err: weighted IR line-position error, one channel per cycle on a shared adder.
// Define IR_LINE_ERR_FILT_EN to average each new error with the previous one.
module ir_line_err
   import ir_line_err_pkg::*;
#(
   parameter int ERR_W = ERR_WIDTH,
   parameter int ACC_W = ACC_WIDTH
) (
   input logic         clk,
   input logic         rst_n,
   ir_line_err_if.slave bus
);
   state_t                  state;
   logic [2:0]              cnt;
   logic signed [ACC_W-1:0] acc, term;
   logic signed [ERR_W-1:0] err_q, sat_new, err_new;
   logic                    vld_q, lost_q;
   logic [11:0]             rd [8];
   ch_t                     ch;
   assign rd = '{bus.IR_L0, bus.IR_L1, bus.IR_L2, bus.IR_L3,
                 bus.IR_R0, bus.IR_R1, bus.IR_R2, bus.IR_R3};
   assign ch = CH_ORDER[cnt];
   assign term = ACC_W'(rd[ch.idx]) << ch.idx[1:0];
   ir_err_sat #(.ACC_W(ACC_W), .ERR_W(ERR_W)) u_sat (.a(acc), .y(sat_new));
`ifdef IR_LINE_ERR_FILT_EN
   logic [ERR_W:0] avg;
   assign avg = {err_q[ERR_W-1], err_q} + {sat_new[ERR_W-1], sat_new};
   assign err_new = avg[ERR_W:1];
`else
   assign err_new = sat_new;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         err_q  <= '0;
         vld_q  <= 1'b0;
         lost_q <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         case (state)
            IDLE: if (bus.IR_vld) begin
               acc   <= '0;
               cnt   <= '0;
               state <= ACCUM;
            end
            ACCUM: begin
               acc   <= ch.sub ? acc - term : acc + term;
               cnt   <= cnt + 3'd1;
               state <= (cnt == 3'd7) ? DONE : ACCUM;
            end
            DONE: begin
               if (bus.line_present) err_q <= err_new;
               lost_q <= ~bus.line_present;
               vld_q  <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.err       = err_q;
   assign bus.err_vld   = vld_q;
   assign bus.line_lost = lost_q;
endmodule

// File: tb/tb_ir_line_err.sv
// tb_ir_line_err: vector table, corner sequences and random rounds against a formula model
module tb_ir_line_err;
   import ir_line_err_pkg::*;
   typedef logic [3:0][11:0] bank_t;
   typedef struct packed {
      bank_t       l;
      bank_t       r;
      logic        lp;
      logic [15:0] e;
      logic        lost;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0, fails = 0;
   int   err_m = 0;
   int   lost_m = 0;
   vec_t vecs [8];
   always #5 clk = ~clk;
   ir_line_err_if #(.ERR_W(16)) bus ();
   ir_line_err #(.ERR_W(16), .ACC_W(18)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic int sat(int x);
      return x > ERR_MAX ? ERR_MAX : x < ERR_MIN ? ERR_MIN : x;
   endfunction

   task automatic chk(string n, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic drive(bank_t l, bank_t r, logic lp);
      bus.IR_L0 = l[0]; bus.IR_L1 = l[1]; bus.IR_L2 = l[2]; bus.IR_L3 = l[3];
      bus.IR_R0 = r[0]; bus.IR_R1 = r[1]; bus.IR_R2 = r[2]; bus.IR_R3 = r[3];
      bus.line_present = lp;
   endtask

   task automatic model(bank_t l, bank_t r, logic lp);
      int raw = 0;
      for (int i = 0; i < 4; i++) raw += (int'(r[i]) - int'(l[i])) * (1 << i);
      if (lp) begin
`ifdef IR_LINE_ERR_FILT_EN
         err_m = (err_m + sat(raw)) >>> 1;
`else
         err_m = sat(raw);
`endif
         lost_m = 0;
      end else lost_m = 1;
   endtask

   // called at a negedge; returns at the negedge after the sampling edge N
   task automatic start(bank_t l, bank_t r, logic lp);
      drive(l, r, lp);
      bus.IR_vld = 1'b1;
      @(negedge clk);
      bus.IR_vld = 1'b0;
   endtask

   task automatic wait_vld(int exp_k, string n);
      int k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.err_vld) begin
            k = i;
            break;
         end
      end
      chk(n, k, exp_k);
   endtask

   task automatic no_vld(int cycles, string n);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.err_vld) seen++;
      end
      chk(n, seen, 0);
   endtask

   task automatic round(bank_t l, bank_t r, logic lp, string n);
      start(l, r, lp);
      model(l, r, lp);
      wait_vld(9, {n, "_latency"});
      chk({n, "_err"}, int'(bus.err), err_m);
      chk({n, "_lost"}, int'(bus.line_lost), lost_m);
   endtask

   initial begin
      bank_t l, r;
      vecs[0] = '{{4{12'h7A5}}, {4{12'h7A5}}, 1'b1, 16'h0000, 1'b0};
      vecs[1] = '{'0, {12'h100, 12'h0, 12'h0, 12'h0}, 1'b1, 16'h0800, 1'b0};
      vecs[2] = '{'0, '0, 1'b0, 16'h0800, 1'b1};
      vecs[3] = '{{36'h0, 12'h005}, {36'h0, 12'h003}, 1'b1, 16'hFFFE, 1'b0};
      vecs[4] = '{{4{12'hFFF}}, '0, 1'b1, 16'h8000, 1'b0};
      vecs[5] = '{'0, {4{12'hFFF}}, 1'b1, 16'h7FFF, 1'b0};
      vecs[6] = '{{12'h0, 12'h003, 24'h0}, {24'h0, 12'h010, 12'h0}, 1'b1, 16'd20, 1'b0};
      vecs[7] = '{'0, '0, 1'b0, 16'd20, 1'b1};
      rst_n = 1'b0;
      bus.IR_vld = 1'b0;
      drive('0, '0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_vld", int'(bus.err_vld), 0);
      chk("rst_lost", int'(bus.line_lost), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         round(vecs[i].l, vecs[i].r, vecs[i].lp, $sformatf("vec%0d", i));
`ifndef IR_LINE_ERR_FILT_EN
         chk($sformatf("vec%0d_tbl_err", i), int'(bus.err), int'($signed(vecs[i].e)));
`endif
         chk($sformatf("vec%0d_tbl_lost", i), int'(bus.line_lost), int'(vecs[i].lost));
      end
      // stray IR_vld mid-round must neither restart nor queue a round
      r = {12'h0, 12'h0, 12'h0, 12'h040};
      start('0, r, 1'b1);
      model('0, r, 1'b1);
      repeat (3) @(negedge clk);
      bus.IR_vld = 1'b1;
      @(negedge clk);
      bus.IR_vld = 1'b0;
      wait_vld(5, "extra_latency");
      chk("extra_err", int'(bus.err), err_m);
      @(negedge clk);
      chk("vld_one_cycle", int'(bus.err_vld), 0);
      no_vld(12, "extra_no_second");
      // reset mid-round discards the partial result
      start({4{12'h123}}, '0, 1'b1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_err", int'(bus.err), 0);
      chk("midrst_vld", int'(bus.err_vld), 0);
      chk("midrst_lost", int'(bus.line_lost), 0);
      @(negedge clk);
      rst_n = 1'b1;
      err_m = 0;
      lost_m = 0;
      no_vld(12, "midrst_no_vld");
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: begin l = {4{12'hFFF}}; r = '0; end
            1: begin l = '0; r = {4{12'hFFF}}; end
            default: for (int i = 0; i < 4; i++) begin
               l[i] = 12'($urandom_range(0, 4095));
               r[i] = 12'($urandom_range(0, 4095));
            end
         endcase
         round(l, r, $urandom_range(0, 4) != 0, $sformatf("rnd%0d", n));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
